// File: rtl/binary_to_bcd_converter.sv
// binary_to_bcd_converter: sequential double-dabble, one shift-and-correct
// step per clock; fixed N+2 cycles from accepted start back to idle.
//
// Ports:
//   clk_i      - clock, rising edge
//   reset_i    - asynchronous active-high reset
//   start_i    - conversion request, sampled in IDLE only
//   binary_i   - unsigned input, captured on the accepted start cycle
//   ready_o    - high in IDLE
//   done_o     - one-cycle pulse in DONE
//   bcd_o      - packed BCD result, digit 0 in [3:0], registered
//   overflow_o - result did not fit in DIGITS digits, registered
module binary_to_bcd_converter #(
    parameter int N      = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [N-1:0]          binary_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o
);

    localparam int CW = $clog2(N) + 1;
    localparam int W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [W-1:0]   work_q, work_d;
    logic           ovf_q, ovf_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   bcd_q, bcd_d;
    logic           ovfo_q, ovfo_d;
    logic [W-1:0]   adj;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovfo_q  <= ovfo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovfo_d  = ovfo_q;

        // Digits >= 5 get +3 so the following shift carries into the
        // next decade exactly when the doubled digit reaches 10.
        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d = binary_i;
                    work_d  = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(N - 1);
                    state_d = OP;
                end
            end
            OP: begin
                work_d  = {adj[W-2:0], shift_q[N-1]};
                shift_d = shift_q << 1;
                // A carry out of the top digit means a decade above
                // DIGITS is non-zero; the low digits stay exact.
                ovf_d   = ovf_q | adj[W-1];
                if (cnt_q == '0) begin
                    state_d = DONE;
                    bcd_d   = work_d;
                    ovfo_d  = ovf_d;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_o    = (state_q == IDLE);
    assign done_o     = (state_q == DONE);
    assign bcd_o      = bcd_q;
    assign overflow_o = ovfo_q;

endmodule

// File: doc/binary_to_bcd_converter.md
# binary_to_bcd_converter

Sequential double-dabble converter that turns an unsigned binary word into packed BCD digits, one shift-and-correct step per clock. It is the inverse companion of the team's BCD-to-binary converter and uses the same start/ready/done handshake, so display and UART formatting paths can use the two blocks interchangeably. Each conversion takes a fixed N+2 cycles from accepted start to return to idle.

## Interface
- N, default 13: binary input width in bits (≥ 1).
- DIGITS, default 4: number of BCD output digits. Output width is 4*DIGITS.
- clk_i  input  1: single clock, rising edge.
- reset_i  input  1: asynchronous, active-high reset.
- start_i  input  1: conversion request; sampled only in IDLE.
- binary_i  input  N: unsigned value; captured on the accepted start cycle only.
- ready_o  output  1: high in IDLE only (combinational from state).
- done_o  output  1: single-cycle pulse in DONE.
- bcd_o  output  4*DIGITS: packed BCD, digit 0 in bits [3:0]. Registered.
- overflow_o  output  1: registered. Set when the value does not fit in DIGITS digits.

## Operation
- State machine: IDLE, OP, DONE. Any unused encoding goes to IDLE.
- IDLE: ready_o=1. On start_i=1:
  - load the shift register with binary_i;
  - clear the BCD working register and the overflow working flag;
  - load the bit counter with N-1;
  - go to OP.
  - With start_i=0, stay in IDLE.
- OP performs one iteration per cycle:
  - Add 3 to every working BCD digit whose value is ≥ 5.
  - Shift {BCD working, binary shift} left by 1. The binary MSB enters BCD bit 0.
  - If the bit shifted out of the top BCD digit is 1, set the overflow working flag (sticky).
  - If the counter is 0, go to DONE. Otherwise decrement the counter and stay in OP.
- OP always runs exactly N iterations. There is no early termination for small values.
- DONE: done_o=1. Go to IDLE unconditionally.
- Output registers:
  - bcd_o and overflow_o load from the working registers on the OP→DONE transition.
  - They hold that value through DONE, IDLE and the whole of the next conversion, until the next OP→DONE.
  - They never show intermediate values.
- start_i is ignored in OP and DONE. It is not queued.
- binary_i changes after the accepted start cycle have no effect.
- Overflow behaviour: bcd_o holds the low DIGITS digits of the decimal value (value mod 10^DIGITS); overflow_o=1.
- The counter width is $clog2(N)+1 bits, so N=1 is legal.

## Timing
- Reset (asynchronous, any state): state=IDLE; bcd_o=0; overflow_o=0; working registers and counter cleared.
  - Outputs after reset: ready_o=1, done_o=0.
- Reset in the middle of OP aborts the conversion. No done_o pulse follows, and bcd_o is 0.
- Cycle T: IDLE with start_i=1 (the accept edge is at the end of T).
- Cycles T+1 … T+N: OP.
- Cycle T+N+1: DONE. done_o=1, and bcd_o/overflow_o are already valid.
- Cycle T+N+2: IDLE, ready_o=1. A new start can be accepted in this cycle.
- Back-to-back throughput: one conversion per N+2 cycles.
- ready_o and done_o are never high in the same cycle.

## Test plan
- After reset, with N=13, DIGITS=4:
  - check ready_o=1, done_o=0, bcd_o=0x0000, overflow_o=0;
  - then binary_i=0 with start → bcd_o=0x0000, overflow_o=0, done_o at exactly T+14.
- Values with N=13, DIGITS=4:
  - binary_i=1234 → bcd_o=0x1234;
  - 8191 → 0x8191;
  - 9 → 0x0009;
  - 10 → 0x0010.
  - overflow_o=0 in every case, and done_o is a one-cycle pulse.
- Ignored start and held inputs, N=13, DIGITS=4:
  - Start with 4321, then hold start_i=1 and change binary_i to 999 throughout OP.
  - Required: result 0x4321, exactly one done_o pulse.
  - Required: the next conversion (999 → 0x0999) is accepted only once ready_o=1.
  - Required: the old bcd_o holds until the new DONE.
- Overflow, N=8, DIGITS=2:
  - 255 → bcd_o=0x55, overflow_o=1;
  - 99 → bcd_o=0x99, overflow_o=0;
  - 100 → bcd_o=0x00, overflow_o=1.
- Reset mid-op, N=13, DIGITS=4:
  - Finish 5678 first (bcd_o=0x5678).
  - Start 1111, then assert reset_i at cycle T+5.
  - Required: immediate IDLE, bcd_o=0, no done_o pulse.
  - Required: a new start with 42 gives 0x0042.
- Randomized sweep against a software reference:
  - all 0…8191 for N=13, DIGITS=4;
  - random N/DIGITS pairs.
  - Check digits, overflow_o, and the N+2 cycle latency.
